// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared Y86-64 constants used by every pipeline stage: instruction codes,
// status codes, the "no register" ID, and the hazard-controller FSM state type.
// Also provides small decode helpers so every stage classifies icodes the
// same way.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // Instruction codes as carried in the icode field of each pipeline register.
    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    // Pipeline status codes.
    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    // Register ID meaning "no register".
    localparam logic [3:0] RNONE = 4'hF;

    // Hazard-controller state: running normally, or frozen after a faulting
    // or halting instruction has reached writeback.
    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_e;

    // True for instructions whose destination is written from memory
    // (the producers of a load/use hazard).
    function automatic logic is_load(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

    // True for any status other than AOK.
    function automatic logic is_exc(input logic [2:0] stat);
        return stat != STAT_AOK;
    endfunction

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Unsigned event counter that counts up by one per cycle while inc is high
// and sticks at all-ones instead of wrapping.
//
// Ports
//   clock  in   sole clock
//   reset  in   synchronous active-low reset, clears the count
//   inc    in   count enable for this cycle
//   count  out  current count value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: every signal written in a combinational block gets a default
    // assignment first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples its input before any register in the design updates.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Hazard and exception controller for a five-stage Y86-64 pipeline. Produces
// the stall/bubble controls for the F, D, E, M and W pipeline registers and
// the condition-code write enable, freezes the pipeline once a non-AOK status
// has retired, and keeps two saturating performance counters.
//
// Ports
//   clock                   in   sole clock
//   reset                   in   synchronous active-low reset
//   D_icode/E_icode/M_icode in   icode held in the decode/execute/memory regs
//   d_srcA, d_srcB          in   decode source register IDs (RNONE = none)
//   E_dstM                  in   load destination in execute (RNONE = none)
//   e_Cnd                   in   branch condition computed in execute
//   m_stat, W_stat          in   status in memory stage / writeback register
//   F_stall,D_stall,W_stall out  stall controls (hold register contents)
//   D_bubble,E_bubble,
//   M_bubble                out  bubble controls (load a NOP)
//   set_cc                  out  condition-code write enable
//   halted                  out  pipeline frozen after a non-AOK retirement
//   stall_cnt               out  RUN cycles with F_stall asserted (saturating)
//   bubble_cnt              out  RUN cycles with a D or E bubble (saturating)
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    logic load_use;
    logic ret_pend;
    logic mispred;
    logic exc_m;
    logic exc_w;

    // A load in execute whose destination feeds an operand being read in decode.
    assign load_use = is_load(E_icode) && (E_dstM != RNONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));

    // A return anywhere between decode and memory: the fetch address is not
    // known until it leaves memory.
    assign ret_pend = (D_icode == I_RET) || (E_icode == I_RET) ||
                      (M_icode == I_RET);

    // Branches are predicted taken, so a not-taken JXX in execute squashes
    // the two younger instructions.
    assign mispred  = (E_icode == I_JXX) && !e_Cnd;

    assign exc_m    = is_exc(m_stat);
    assign exc_w    = is_exc(W_stat);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    state_e state_q;
    state_e state_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state. HALTED is left only through reset.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:    if (exc_w) state_d = S_HALTED;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        W_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        set_cc   = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            S_RUN: begin
                F_stall  = load_use || ret_pend;
                // A mispredicted branch squashes D, so holding D would keep a
                // wrong-path instruction; mispred therefore overrides the stall.
                D_stall  = load_use && !mispred;
                // A load/use stall holds D, so it must not also be bubbled.
                D_bubble = mispred || (!load_use && ret_pend);
                E_bubble = mispred || load_use;
                // Once an exception reaches M or W, nothing younger may
                // update memory or the condition codes.
                M_bubble = exc_m || exc_w;
                W_stall  = exc_w;
                set_cc   = (E_icode == I_OPQ) && !exc_m && !exc_w;
            end
            S_HALTED: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
                M_bubble = 1'b1;
                halted   = 1'b1;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Performance counters: count RUN cycles only. The counters' own reset
    // takes priority over inc, so the reset cycle is never counted.
    // -------------------------------------------------------------------------
    logic running;
    logic stall_inc;
    logic bubble_inc;

    assign running    = (state_q == S_RUN);
    assign stall_inc  = running && F_stall;
    assign bubble_inc = running && (D_bubble || E_bubble);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed vectors for pipe_ctrl. Each vector is applied just after a rising
// edge; its hand-computed expected controls and counter values are queued,
// and a monitor compares them at the following falling edge. Two instances
// share the stimulus: the default 16-bit counters and a 4-bit version used
// to see saturation.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    // Control word order: {F_stall,D_stall,W_stall,D_bubble,E_bubble,M_bubble,set_cc,halted}
    localparam logic [7:0] C_NONE    = 8'b0000_0000;
    localparam logic [7:0] C_LU      = 8'b1100_1000;
    localparam logic [7:0] C_MIS     = 8'b0001_1000;
    localparam logic [7:0] C_RET     = 8'b1001_0000;
    localparam logic [7:0] C_RET_MIS = 8'b1001_1000;
    localparam logic [7:0] C_CC      = 8'b0000_0010;
    localparam logic [7:0] C_EXCM    = 8'b0000_0100;
    localparam logic [7:0] C_EXCW    = 8'b0010_0100;
    localparam logic [7:0] C_HALT    = 8'b1110_0101;

    typedef struct packed {
        logic [3:0] d_icode;
        logic [3:0] e_icode;
        logic [3:0] m_icode;
        logic [3:0] srca;
        logic [3:0] srcb;
        logic [3:0] dstm;
        logic       cnd;
        logic [2:0] mstat;
        logic [2:0] wstat;
    } stim_t;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [15:0] st;
        logic [15:0] bu;
        logic [3:0]  st4;
        logic [3:0]  bu4;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [3:0]  D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM;
    logic        e_Cnd;
    logic [2:0]  m_stat, W_stat;

    logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, halted;
    logic [15:0] stall_cnt, bubble_cnt;
    logic        F_stall4, D_stall4, W_stall4, D_bubble4, E_bubble4, M_bubble4, set_cc4, halted4;
    logic [3:0]  stall_cnt4, bubble_cnt4;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    pipe_ctrl #(.CNT_W(16)) u_dut (
        .clock(clock), .reset(reset),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .set_cc(set_cc), .halted(halted),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall4), .D_stall(D_stall4), .W_stall(W_stall4),
        .D_bubble(D_bubble4), .E_bubble(E_bubble4), .M_bubble(M_bubble4),
        .set_cc(set_cc4), .halted(halted4),
        .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic stim_t mk(input logic [3:0] d, e, m, sa, sb, dm,
                                 input logic c, input logic [2:0] ms, ws);
        stim_t s;
        s = '{d_icode: d, e_icode: e, m_icode: m, srca: sa, srcb: sb,
              dstm: dm, cnd: c, mstat: ms, wstat: ws};
        return s;
    endfunction

    task automatic drive(input logic rst, input stim_t s);
        reset   = rst;
        D_icode = s.d_icode;
        E_icode = s.e_icode;
        M_icode = s.m_icode;
        d_srcA  = s.srca;
        d_srcB  = s.srcb;
        E_dstM  = s.dstm;
        e_Cnd   = s.cnd;
        m_stat  = s.mstat;
        W_stat  = s.wstat;
    endtask

    // Apply one vector for one cycle and queue what the monitor should see.
    // st/bu are the counter values before this vector's own cycle is counted.
    task automatic vec(input string name, input logic rst, input stim_t s,
                       input logic [7:0] ctrl, input int st, input int bu,
                       input int st4, input int bu4);
        exp_t e;
        @(posedge clock);
        #1;
        drive(rst, s);
        e = '{ctrl: ctrl, st: 16'(st), bu: 16'(bu), st4: 4'(st4), bu4: 4'(bu4)};
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, ".ctrl"}, 32'({F_stall, D_stall, W_stall, D_bubble,
                                         E_bubble, M_bubble, set_cc, halted}), 32'(e.ctrl));
                check({n, ".ctrl4"}, 32'({F_stall4, D_stall4, W_stall4, D_bubble4,
                                          E_bubble4, M_bubble4, set_cc4, halted4}), 32'(e.ctrl));
                check({n, ".stall_cnt"}, 32'(stall_cnt), 32'(e.st));
                check({n, ".bubble_cnt"}, 32'(bubble_cnt), 32'(e.bu));
                check({n, ".stall_cnt4"}, 32'(stall_cnt4), 32'(e.st4));
                check({n, ".bubble_cnt4"}, 32'(bubble_cnt4), 32'(e.bu4));
            end
        end
    end

    initial begin
        stim_t idle, lu, lu_b, mr_none, mr_nom, mis, jtk, ret_d, ret_e, ret_m,
               ret_lu, ret_mis, opq, opq_em, exc_w, lu_aok;
        idle    = mk(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
        lu      = mk(4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b1, 3'd1, 3'd1);
        lu_b    = mk(4'h1, 4'hB, 4'h1, 4'h2, 4'h4, 4'h4, 1'b1, 3'd1, 3'd1);
        mr_none = mk(4'h1, 4'h5, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
        mr_nom  = mk(4'h1, 4'h5, 4'h1, 4'h1, 4'h2, 4'h3, 1'b1, 3'd1, 3'd1);
        mis     = mk(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1);
        jtk     = mk(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
        ret_d   = mk(4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
        ret_e   = mk(4'h1, 4'h9, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
        ret_m   = mk(4'h1, 4'h1, 4'h9, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
        ret_lu  = mk(4'h9, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b1, 3'd1, 3'd1);
        ret_mis = mk(4'h9, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1);
        opq     = mk(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
        opq_em  = mk(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd3, 3'd1);
        exc_w   = mk(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd3);
        lu_aok  = lu;

        drive(1'b0, idle);
        repeat (2) @(posedge clock);

        //   name                 rst  stim     ctrl       st  bu  st4 bu4
        vec("reset_idle",        1'b0, idle,    C_NONE,     0,  0,  0,  0);
        vec("idle_run",          1'b1, idle,    C_NONE,     0,  0,  0,  0);
        vec("load_use_srcA",     1'b1, lu,      C_LU,       0,  0,  0,  0);
        vec("load_use_popq_srcB",1'b1, lu_b,    C_LU,       1,  1,  1,  1);
        vec("mrmovq_dst_none",   1'b1, mr_none, C_NONE,     2,  2,  2,  2);
        vec("mrmovq_no_match",   1'b1, mr_nom,  C_NONE,     2,  2,  2,  2);
        vec("mispred",           1'b1, mis,     C_MIS,      2,  2,  2,  2);
        vec("jxx_taken",         1'b1, jtk,     C_NONE,     2,  3,  2,  3);
        vec("ret_in_D",          1'b1, ret_d,   C_RET,      2,  3,  2,  3);
        vec("ret_in_E",          1'b1, ret_e,   C_RET,      3,  4,  3,  4);
        vec("ret_in_M",          1'b1, ret_m,   C_RET,      4,  5,  4,  5);
        vec("ret_and_load_use",  1'b1, ret_lu,  C_LU,       5,  6,  5,  6);
        vec("ret_and_mispred",   1'b1, ret_mis, C_RET_MIS,  6,  7,  6,  7);
        vec("opq_set_cc",        1'b1, opq,     C_CC,       7,  8,  7,  8);
        vec("opq_exc_m",         1'b1, opq_em,  C_EXCM,     7,  8,  7,  8);
        vec("exc_w_run",         1'b1, exc_w,   C_EXCW,     7,  8,  7,  8);
        vec("halted_load_use",   1'b1, lu_aok,  C_HALT,     7,  8,  7,  8);
        vec("halted_idle",       1'b1, idle,    C_HALT,     7,  8,  7,  8);
        vec("reset_from_halt",   1'b0, lu,      C_HALT,     7,  8,  7,  8);
        vec("after_reset_lu",    1'b1, lu,      C_LU,       0,  0,  0,  0);

        // Hold the load/use hazard: the 4-bit counters must stop at 15.
        for (int i = 0; i < 20; i++) begin
            vec("sat_hold", 1'b1, lu, C_LU, 1 + i, 1 + i,
                (1 + i > 15) ? 15 : 1 + i, (1 + i > 15) ? 15 : 1 + i);
        end
        vec("sat_idle_0",        1'b1, idle,    C_NONE,    21, 21, 15, 15);
        vec("sat_idle_1",        1'b1, idle,    C_NONE,    21, 21, 15, 15);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipe_ctrl

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the saturating performance counters.
REQ-002 clock  input  1  sole clock, all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 D_icode  input  4  instruction code in decode register.
REQ-005 E_icode  input  4  instruction code in execute register.
REQ-006 M_icode  input  4  instruction code in memory register.
REQ-007 d_srcA, d_srcB  input  4 each  source register IDs in decode; 4'hF = none.
REQ-008 E_dstM  input  4  load destination register in execute; 4'hF = none.
REQ-009 e_Cnd  input  1  branch condition from execute-stage condition logic.
REQ-010 m_stat, W_stat  input  3 each  status in memory and writeback (1 AOK, 2 HLT, 3 ADR, 4 INS).
REQ-011 F_stall, D_stall, W_stall  output  1 each  stall controls for the pipeline registers.
REQ-012 D_bubble, E_bubble, M_bubble  output  1 each  bubble controls for the pipeline registers.
REQ-013 set_cc  output  1  condition-code write enable.
REQ-014 halted  output  1  pipeline frozen after a non-AOK status has retired.
REQ-015 stall_cnt, bubble_cnt  output  CNT_W each  saturating event counters.

Function
REQ-016 Icodes: HALT 0, NOP 1, RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B.
REQ-017 load_use = E_icode in {MRMOVQ,POPQ} and E_dstM != F and E_dstM in {d_srcA,d_srcB}.
REQ-018 ret_pend = RET in {D_icode,E_icode,M_icode}; mispred = E_icode==JXX and !e_Cnd.
REQ-019 exc_m = m_stat != AOK; exc_w = W_stat != AOK.
REQ-020 In RUN: F_stall = load_use | ret_pend; D_stall = load_use.
REQ-021 In RUN: D_bubble = mispred | (!load_use & ret_pend); E_bubble = mispred | load_use.
REQ-022 In RUN: M_bubble = exc_m | exc_w; W_stall = exc_w; set_cc = E_icode==OPQ & !exc_m & !exc_w.
REQ-023 All control outputs are combinational from inputs and state; zero-cycle latency.
REQ-024 Two-state FSM RUN/HALTED; RUN->HALTED at the posedge where exc_w is 1; HALTED exits only on reset.
REQ-025 In HALTED: F_stall, D_stall, W_stall = 1; M_bubble = 1; D_bubble, E_bubble, set_cc = 0; halted = 1.
REQ-026 Stall and bubble never both asserted on one register; D_stall has priority over D_bubble.
REQ-027 stall_cnt increments by 1 each RUN cycle with F_stall=1; bubble_cnt increments by 1 each RUN cycle with D_bubble|E_bubble=1.
REQ-028 Counters saturate at all-ones; no wrap; no counting in HALTED.
REQ-029 Simultaneous mispred and load_use: E_bubble=1, D_bubble=1, D_stall=1 is forbidden, resolve D_stall=0 (mispred wins since E holds JXX, load_use is impossible; implementation shall still apply mispred priority).

Reset
REQ-030 When reset=0 at posedge: state=RUN, stall_cnt=0, bubble_cnt=0, halted=0.
REQ-031 Reset mid-HALTED or mid-stall returns to RUN next cycle; combinational outputs reflect inputs immediately after.
REQ-032 During reset cycle counters do not increment.

Structure
REQ-033 Icode, stat encodings and RNONE constant shall live in a shared y86 constants package used by all stages.
REQ-034 One sub-module, sat_counter (CNT_W parameter, inc, reset), instantiated twice.
REQ-035 Outputs drive stall/bubble ports of the existing pipeline registers directly.

Verification
REQ-036 E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt +1.
REQ-037 E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; bubble_cnt +1.
REQ-038 D_icode=9 then E, then M for 3 cycles -> F_stall=1 and D_bubble=1 each cycle; stall_cnt=3.
REQ-039 E_icode=6, m_stat=3 -> set_cc=0, M_bubble=1; next W_stat=3 -> halted=1 following cycle, outputs per REQ-025 held until reset=0.
REQ-040 CNT_W=4, load_use held 20 cycles -> stall_cnt=15 and stays 15.
